div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 43 ++++
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32IM radix-2 restoring divider: op select codes,
// FSM encoding and the ALU-code to div_op mapping used by decode.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_MUL  = 5'd8,
    ALU_DIV  = 5'd12,
    ALU_DIVU = 5'd13,
    ALU_REM  = 5'd14,
    ALU_REMU = 5'd15
  } alu_op_e;

  // Decode helper: the ID/EX register stores this value as div_op.
  function automatic logic [1:0] alu_to_div_op(input alu_op_e op);
    logic [1:0] r;
    case (op)
      ALU_DIV:  r = DIV_OP_DIV;
      ALU_DIVU: r = DIV_OP_DIVU;
      ALU_REM:  r = DIV_OP_REM;
      ALU_REMU: r = DIV_OP_REMU;
      default:  r = DIV_OP_DIV;
    endcase
    return r;
  endfunction

  function automatic logic is_div_alu_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU in EX.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  div_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN:0]    rem_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  dvs_r;
  logic             rem_sel_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             done_r;
  logic [XLEN-1:0]  result_r;

  logic             is_signed_s;
  logic             is_rem_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  a_mag_s;
  logic [XLEN-1:0]  b_mag_s;
  logic             special_s;
  logic [XLEN-1:0]  special_res_s;
  logic [XLEN+1:0]  rem_sh_s;
  logic [XLEN+1:0]  diff_s;
  logic             borrow_s;
  logic [XLEN:0]    rem_nx_s;
  logic [XLEN-1:0]  quo_nx_s;
  logic [XLEN-1:0]  final_s;
  logic             last_iter_s;

  assign is_signed_s = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
  assign is_rem_s    = div_op[1];
  assign a_neg_s     = is_signed_s & rs1_val[XLEN-1];
  assign b_neg_s     = is_signed_s & rs2_val[XLEN-1];
  assign a_mag_s     = a_neg_s ? neg2(rs1_val) : rs1_val;
  assign b_mag_s     = b_neg_s ? neg2(rs2_val) : rs2_val;

  // Operand pairs that resolve without iterating, and their architectural result.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = '0;
    if (rs2_val == '0) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? rs1_val : '1;
    end else if (is_signed_s && (rs1_val == INT_MIN) && (rs2_val == '1)) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? '0 : INT_MIN;
`ifdef DIV_EARLY_OUT_EN
    end else if (a_mag_s < b_mag_s) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? rs1_val : '0;
`endif
    end else begin
      special_s     = 1'b0;
      special_res_s = '0;
    end
  end

  // One restoring step; the extra top bits expose the borrow of the trial subtract.
  assign rem_sh_s    = {rem_r, quo_r[XLEN-1]};
  assign diff_s      = rem_sh_s - {2'b00, dvs_r};
  assign borrow_s    = diff_s[XLEN+1];
  assign rem_nx_s    = borrow_s ? rem_sh_s[XLEN:0] : diff_s[XLEN:0];
  assign quo_nx_s    = {quo_r[XLEN-2:0], ~borrow_s};
  assign last_iter_s = (cnt_r == CNT_W'(XLEN - 1));

  // Sign fix-up applied to the value leaving the last iteration.
  always_comb begin
    final_s = '0;
    if (rem_sel_r) begin
      final_s = neg_r_r ? neg2(rem_nx_s[XLEN-1:0]) : rem_nx_s[XLEN-1:0];
    end else begin
      final_s = neg_q_r ? neg2(quo_nx_s) : quo_nx_s;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      rem_sel_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            cnt_r     <= '0;
            rem_sel_r <= is_rem_s;
            if (special_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= special_res_s;
            end else begin
              state_r <= CALC;
              rem_r   <= '0;
              quo_r   <= a_mag_s;
              dvs_r   <= b_mag_s;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_r <= IDLE;
          end else begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_iter_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= final_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // stall must rise in the same cycle start is presented, so it decodes start directly.
  assign stall  = ((state_r == IDLE) && start && !flush) || (state_r == CALC);
  assign busy   = (state_r != IDLE);
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, special cases,
// flush, async reset and back-to-back issue.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  div_op;
  logic        flush;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 0;
`else
  localparam int EO_LAT = 32;
`endif

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .div_op  (div_op),
    .flush   (flush),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, scramble inputs afterwards, measure edges from E0 to done.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   cyc;
    logic stall_ok;
    start = 1'b1; div_op = op; rs1_val = a; rs2_val = b;
    #1 chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; div_op = ~op; rs1_val = ~a; rs2_val = b + 32'd3;
    cyc = 0;
    stall_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_stall_calc"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int   cyc;
    logic seen;
    rst = 1'b1; start = 1'b0; div_op = 2'b00; flush = 1'b0;
    rs1_val = 32'd0; rs2_val = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("div_100_7",   2'b00, 32'd100,        32'd7,          32'd14,         32);
    do_op("rem_100_7",   2'b10, 32'd100,        32'd7,          32'd2,          32);
    do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32);
    do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32);
    do_op("div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32);
    do_op("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32);
    do_op("divu_max_1",  2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32);

    // Flush sampled at E10 kills the op; result keeps 0xFFFFFFFF.
    start = 1'b1; div_op = 2'b01; rs1_val = 32'd1000; rs2_val = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", 32'(busy), 32'd0);
    chk("flush_stall_after", 32'(stall), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_result", result, 32'hFFFF_FFFF);

    // start together with flush in IDLE is ignored.
    start = 1'b1; flush = 1'b1; div_op = 2'b00; rs1_val = 32'd100; rs2_val = 32'd7;
    #1 chk("flush_start_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    chk("flush_start_done", 32'(done), 32'd0);
    chk("flush_start_result", result, 32'hFFFF_FFFF);

    do_op("div_5_0",     2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  0);
    do_op("remu_5_0",    2'b11, 32'd5,          32'd0,          32'd5,          0);
    do_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0);
    do_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0);
    do_op("divu_3_10",   2'b01, 32'd3,          32'd10,         32'd0,          EO_LAT);

    // Back-to-back: start held high; the second op is taken only at E34.
    start = 1'b1; div_op = 2'b01; rs1_val = 32'd9; rs2_val = 32'd3;
    @(negedge clk);
    div_op = 2'b11; rs1_val = 32'd9; rs2_val = 32'd4;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_lat", 32'(cyc), 32'd32);
    chk("b2b_first_res", result, 32'd3);
    @(negedge clk);
    cyc++;
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    cyc++;
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_lat", 32'(cyc), 32'd66);
    chk("b2b_second_res", result, 32'd1);
    @(negedge clk);

    // Async reset during iteration 20 clears everything without a clock edge.
    start = 1'b1; div_op = 2'b00; rs1_val = 32'd100; rs2_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("arst_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("arst_no_done", 32'(seen), 32'd0);

    do_op("div_after_rst", 2'b00, 32'd100, 32'd7, 32'd14, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
